// File: rtl/missile_ctl.sv
`default_nettype none
// ============================================================================
// Module   : missile_ctl
// Brief    : Single player missile: launch from ship, upward flight per frame
//            tick, retire at top or on hit, frame-counted reload interval.
//            Build option: MISSILE_AUTOFIRE_EN (level-sensitive fire).
// Revision : 1.0 - initial release
// ============================================================================
module missile_ctl #(
    parameter int SPEED          = 8,
    parameter int MISSILE_HEIGHT = 20,
    parameter int Y_TOP          = 0,
    parameter int RELOAD_FRAMES  = 10
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        fire,
    input  logic        hit,
    input  logic [11:0] ship_xpos,
    input  logic [11:0] ship_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        on,
    output logic        busy
);

    localparam int          C_CNT_W  = (RELOAD_FRAMES > 0) ? $clog2(RELOAD_FRAMES + 1) : 1;
    localparam logic [11:0] C_SPEED  = 12'(SPEED);
    localparam logic [11:0] C_HEIGHT = 12'(MISSILE_HEIGHT);
    // 13 bits so Y_TOP+SPEED near the top of the 12-bit range cannot alias
    localparam logic [12:0] C_MIN_Y  = 13'(Y_TOP + SPEED);
    localparam logic [C_CNT_W-1:0] C_RELOAD = C_CNT_W'(RELOAD_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLY    = 2'd1,
        S_RELOAD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]          xpos_q, xpos_d;
    logic [11:0]          ypos_q, ypos_d;
    logic                 on_q, on_d;
    logic                 busy_q, busy_d;
    logic                 vsync_q;
    logic                 w_tick;
    logic                 w_launch;

    assign w_tick = vsync_in & ~vsync_q;

`ifdef MISSILE_AUTOFIRE_EN
    assign w_launch = fire;
`else
    logic fire_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            fire_q <= 1'b0;
        end else begin
            fire_q <= fire;
        end
    end

    assign w_launch = fire & ~fire_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        case (state_q)
            S_IDLE: begin
                if (w_launch) begin
                    state_d = S_FLY;
                    xpos_d  = ship_xpos;
                    ypos_d  = (ship_ypos >= C_HEIGHT) ? (ship_ypos - C_HEIGHT) : 12'd0;
                end
            end
            S_FLY: begin
                if (hit) begin
                    state_d = S_RELOAD;
                    cnt_d   = '0;
                end else if (w_tick) begin
                    if ({1'b0, ypos_q} >= C_MIN_Y) begin
                        ypos_d = ypos_q - C_SPEED;
                    end else begin
                        state_d = S_RELOAD;
                        cnt_d   = '0;
                    end
                end
            end
            S_RELOAD: begin
                if (RELOAD_FRAMES == 0) begin
                    state_d = S_IDLE;
                end else if (w_tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == C_RELOAD) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        on_d   = (state_d == S_FLY);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            xpos_q  <= 12'd0;
            ypos_q  <= 12'd0;
            on_q    <= 1'b0;
            busy_q  <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            on_q    <= on_d;
            busy_q  <= busy_d;
            vsync_q <= vsync_in;
        end
    end

    assign xpos = xpos_q;
    assign ypos = ypos_q;
    assign on   = on_q;
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_missile_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_missile_ctl
// Brief    : Directed self-checking bench for missile_ctl (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_missile_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic        vsync_in;
    logic        fire;
    logic        hit;
    logic [11:0] ship_xpos;
    logic [11:0] ship_ypos;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        on;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    missile_ctl dut (
        .pclk      (pclk),
        .rst       (rst),
        .vsync_in  (vsync_in),
        .fire      (fire),
        .hit       (hit),
        .ship_xpos (ship_xpos),
        .ship_ypos (ship_ypos),
        .xpos      (xpos),
        .ypos      (ypos),
        .on        (on),
        .busy      (busy)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // One frame: vsync high for 2 cycles, low for 1; the tick lands on the first edge.
    task automatic frame();
        vsync_in = 1'b1;
        step(2);
        vsync_in = 1'b0;
        step(1);
    endtask

    task automatic pulse_fire();
        fire = 1'b1;
        step(1);
        fire = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vsync_in = 1'b0; fire = 1'b1; hit = 1'b0;
        ship_xpos = 12'd0; ship_ypos = 12'd0;

        // Reset with fire held
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rst_on", {11'd0, on}, 12'd0);
            chk("rst_busy", {11'd0, busy}, 12'd0);
            chk("rst_xpos", xpos, 12'd0);
            chk("rst_ypos", ypos, 12'd0);
        end
        rst = 1'b0; fire = 1'b0;
        step(1);
        chk("post_rst_on", {11'd0, on}, 12'd0);
        chk("post_rst_busy", {11'd0, busy}, 12'd0);

        // hit in IDLE has no effect
        hit = 1'b1; step(1); hit = 1'b0;
        chk("idle_hit_busy", {11'd0, busy}, 12'd0);

        // Launch and flight
        ship_xpos = 12'd300; ship_ypos = 12'd540;
        pulse_fire();
        chk("launch_on", {11'd0, on}, 12'd1);
        chk("launch_busy", {11'd0, busy}, 12'd1);
        chk("launch_xpos", xpos, 12'd300);
        chk("launch_ypos", ypos, 12'd520);
        ship_xpos = 12'd100;
        step(2);
        chk("hold_ypos", ypos, 12'd520);
        vsync_in = 1'b1;
        chk("pre_tick_ypos", ypos, 12'd520);
        step(1);
        chk("tick1_ypos", ypos, 12'd512);
        step(1);
        chk("once_per_frame", ypos, 12'd512);
        vsync_in = 1'b0;
        step(1);
        frame();
        chk("tick2_ypos", ypos, 12'd504);
        frame();
        chk("tick3_ypos", ypos, 12'd496);
        chk("xpos_no_track", xpos, 12'd300);

        // Hit retire, then full reload
        hit = 1'b1; step(1); hit = 1'b0;
        chk("hit_on", {11'd0, on}, 12'd0);
        chk("hit_busy", {11'd0, busy}, 12'd1);
        chk("hit_ypos", ypos, 12'd496);
        for (int i = 0; i < 9; i++) frame();
        chk("reload9_busy", {11'd0, busy}, 12'd1);
        frame();
        chk("reload10_busy", {11'd0, busy}, 12'd0);

        // Top retire: 20 -> 12 -> 4 -> retire
        ship_xpos = 12'd50; ship_ypos = 12'd40;
        pulse_fire();
        chk("top_spawn_ypos", ypos, 12'd20);
        frame();
        chk("top_t1", ypos, 12'd12);
        frame();
        chk("top_t2", ypos, 12'd4);
        chk("top_t2_on", {11'd0, on}, 12'd1);
        frame();
        chk("top_retire_on", {11'd0, on}, 12'd0);
        chk("top_retire_busy", {11'd0, busy}, 12'd1);
        chk("top_retire_ypos", ypos, 12'd4);
        pulse_fire(); step(1);
        chk("reload_fire_ign_on", {11'd0, on}, 12'd0);
        for (int i = 0; i < 9; i++) begin
            frame();
            if (i == 4) begin
                pulse_fire(); step(1);
            end
        end
        chk("top_reload9_busy", {11'd0, busy}, 12'd1);
        chk("top_reload9_on", {11'd0, on}, 12'd0);
        frame();
        chk("top_reload10_busy", {11'd0, busy}, 12'd0);
        chk("top_reload10_on", {11'd0, on}, 12'd0);

        // Hit and tick in the same cycle at ypos=200
        ship_ypos = 12'd220;
        pulse_fire();
        chk("hp_spawn", ypos, 12'd200);
        hit = 1'b1; vsync_in = 1'b1;
        step(1);
        hit = 1'b0;
        chk("hp_on", {11'd0, on}, 12'd0);
        chk("hp_ypos", ypos, 12'd200);
        chk("hp_busy", {11'd0, busy}, 12'd1);
        step(1); vsync_in = 1'b0; step(1);
        for (int i = 0; i < 9; i++) frame();
        chk("hp_reload9_busy", {11'd0, busy}, 12'd1);
        frame();
        chk("hp_reload10_busy", {11'd0, busy}, 12'd0);

        // Spawn clamp
        ship_xpos = 12'd5; ship_ypos = 12'd10;
        pulse_fire();
        chk("clamp_ypos", ypos, 12'd0);
        chk("clamp_on", {11'd0, on}, 12'd1);
        step(4);
        chk("clamp_hold_on", {11'd0, on}, 12'd1);
        frame();
        chk("clamp_retire_on", {11'd0, on}, 12'd0);
        chk("clamp_no_wrap", ypos, 12'd0);
        for (int i = 0; i < 10; i++) frame();
        chk("clamp_reload_busy", {11'd0, busy}, 12'd0);

        // Fire held across two shots
        ship_ypos = 12'd40;
        fire = 1'b1;
        step(1);
        chk("af_first_on", {11'd0, on}, 12'd1);
        for (int i = 0; i < 3; i++) frame();
        chk("af_retire_on", {11'd0, on}, 12'd0);
        for (int i = 0; i < 9; i++) frame();
        chk("af_reload9_busy", {11'd0, busy}, 12'd1);
        vsync_in = 1'b1;
        step(1);
        chk("af_reload_end_busy", {11'd0, busy}, 12'd0);
        chk("af_reload_end_on", {11'd0, on}, 12'd0);
        step(1);
`ifdef MISSILE_AUTOFIRE_EN
        chk("af_relaunch_on", {11'd0, on}, 12'd1);
        chk("af_relaunch_ypos", ypos, 12'd20);
        vsync_in = 1'b0;
        step(1);
`else
        chk("af_no_relaunch_on", {11'd0, on}, 12'd0);
        vsync_in = 1'b0;
        step(3);
        chk("af_still_idle", {11'd0, busy}, 12'd0);
        fire = 1'b0;
        step(1);
        chk("af_release_idle", {11'd0, on}, 12'd0);
        fire = 1'b1;
        step(1);
        chk("af_repress_on", {11'd0, on}, 12'd1);
        chk("af_repress_ypos", ypos, 12'd20);
`endif
        fire = 1'b0;

        // Reset mid-flight
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_on", {11'd0, on}, 12'd0);
        chk("midrst_busy", {11'd0, busy}, 12'd0);
        chk("midrst_xpos", xpos, 12'd0);
        chk("midrst_ypos", ypos, 12'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
